multi_channel_echo: RTL

MULTI_CHANNEL_ECHO -- requirements
Module: multi_channel_echo

---
 rtl/echo_pkg.sv | 27 ++
 rtl/echo_ram.sv | 35 +++
 rtl/multi_channel_echo.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// echo_pkg
//   Shared definitions for the multi-channel echo block:
//   - echo_state_e : controller states
//   - sat_max/sat_min : clamp limits of a two's-complement word of a given
//     width, used when the ECHO_SATURATE_EN build option is enabled.
package echo_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    READ  = 3'd2,
    CALC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } echo_state_e;

  // Largest value representable in a signed word of 'bits' bits.
  function automatic longint sat_max(input int bits);
    return (longint'(1) <<< (bits - 1)) - 1;
  endfunction

  // Smallest value representable in a signed word of 'bits' bits.
  function automatic longint sat_min(input int bits);
    return -(longint'(1) <<< (bits - 1));
  endfunction

endpackage

// File: rtl/echo_ram.sv
// echo_ram
//   Single-port delay memory with a registered (one-cycle) read, written so
//   that synthesis maps it onto block RAM. No reset: contents are cleared by
//   the controller's initialisation sweep instead.
// Ports:
//   clk_i   : clock, rising edge
//   we_i    : write enable for the current address
//   addr_i  : read/write address
//   wdata_i : data written when we_i is high
//   rdata_o : data at the address presented on the previous cycle
module echo_ram #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_BITS = 11
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_BITS-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1 << DEPTH_BITS) - 1];
  logic [WIDTH-1:0] rdata_q;

  // Read-first single port: the read register always samples the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_channel_echo.sv
// multi_channel_echo
//   Feedback echo for CHANNELS independent audio channels. Each frame
//   (rising edge of the synchronised lrclk) every channel computes
//     y = x + (y_delayed >>> GAIN_SHIFT)
//   where y_delayed is the output of the same channel 'delay' frames ago,
//   read from a shared delay memory. The result is both the output sample
//   and the value fed back into the memory.
//
// Build option:
//   ECHO_SATURATE_EN : when defined, y clamps to the signed BITSIZE range;
//                      otherwise y wraps (low BITSIZE bits are kept).
//
// Ports:
//   bclk      : clock, everything on the rising edge
//   rst       : asynchronous active-low reset
//   lrclk     : frame clock (asynchronous, synchronised internally)
//   delay     : echo delay in frames; 0 disables the echo
//   bypass    : 1 passes the dry input straight through
//   in_data   : channel c at [c*BITSIZE +: BITSIZE]
//   out_data  : processed samples, same packing as in_data
//   out_valid : one-cycle pulse when out_data updates
//   busy      : high whenever the controller is not idle
//   overrun   : sticky, set when a frame arrives while a frame is in progress
module multi_channel_echo
  import echo_pkg::*;
#(
  parameter int BITSIZE    = 16,
  parameter int ADDRBITS   = 10,
  parameter int CHANNELS   = 2,
  parameter int GAIN_SHIFT = 1
) (
  input  logic                         bclk,
  input  logic                         rst,
  input  logic                         lrclk,
  input  logic [ADDRBITS-1:0]          delay,
  input  logic                         bypass,
  input  logic [CHANNELS*BITSIZE-1:0]  in_data,
  output logic [CHANNELS*BITSIZE-1:0]  out_data,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = ADDRBITS + CW;
  localparam int DW = CHANNELS * BITSIZE;
  localparam logic [CW-1:0] LastChan = CW'(CHANNELS - 1);

`ifdef ECHO_SATURATE_EN
  localparam logic signed [BITSIZE:0] SatHiW = (BITSIZE + 1)'(sat_max(BITSIZE));
  localparam logic signed [BITSIZE:0] SatLoW = (BITSIZE + 1)'(sat_min(BITSIZE));
`endif

  logic                lrSync1_q, lrSync2_q, lrPrev_q;
  logic                frameEvent;

  echo_state_e         state_q, state_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [ADDRBITS-1:0] wrPtr_q, wrPtr_d;
  logic [DW-1:0]       inCap_q, inCap_d;
  logic [ADDRBITS-1:0] delayCap_q, delayCap_d;
  logic                bypassCap_q, bypassCap_d;
  logic [DW-1:0]       yBuf_q, yBuf_d;
  logic [DW-1:0]       outData_q, outData_d;
  logic                outValid_q, outValid_d;
  logic                overrun_q, overrun_d;

  logic                ramWe;
  logic [AW-1:0]       ramAddr;
  logic [BITSIZE-1:0]  ramWdata;
  logic [BITSIZE-1:0]  ramRdata;

  logic signed [BITSIZE-1:0] xCur;
  logic signed [BITSIZE-1:0] dCur;
  logic signed [BITSIZE-1:0] dScaled;
  logic [BITSIZE-1:0]        yNarrow;
  logic [BITSIZE-1:0]        yCalc;
`ifdef ECHO_SATURATE_EN
  logic [BITSIZE:0]          sumWide;
`endif

  // Two-flop synchroniser for lrclk plus one extra flop so a rising edge of
  // the synchronised signal can be detected.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      lrSync1_q <= 1'b0;
      lrSync2_q <= 1'b0;
      lrPrev_q  <= 1'b0;
    end else begin
      lrSync1_q <= lrclk;
      lrSync2_q <= lrSync1_q;
      lrPrev_q  <= lrSync2_q;
    end
  end

  assign frameEvent = lrSync2_q & ~lrPrev_q;

  echo_ram #(
    .WIDTH      (BITSIZE),
    .DEPTH_BITS (AW)
  ) uRam (
    .clk_i   (bclk),
    .we_i    (ramWe),
    .addr_i  (ramAddr),
    .wdata_i (ramWdata),
    .rdata_o (ramRdata)
  );

  // Per-channel arithmetic. The RAM word read in READ is valid during CALC.
  // A zero delay would read the slot about to be overwritten, so the echo
  // term is forced to zero instead.
  always_comb begin
    xCur    = inCap_q[chan_q*BITSIZE +: BITSIZE];
    dCur    = (delayCap_q == '0) ? '0 : ramRdata;
    dScaled = dCur >>> GAIN_SHIFT;
`ifdef ECHO_SATURATE_EN
    sumWide = {xCur[BITSIZE-1], xCur} + {dScaled[BITSIZE-1], dScaled};
    if ($signed(sumWide) > SatHiW) begin
      yNarrow = SatHiW[BITSIZE-1:0];
    end else if ($signed(sumWide) < SatLoW) begin
      yNarrow = SatLoW[BITSIZE-1:0];
    end else begin
      yNarrow = sumWide[BITSIZE-1:0];
    end
`else
    // Keeping only the low BITSIZE bits of the widened sum is the same as
    // a native-width add, so the carry bit is never built.
    yNarrow = xCur + dScaled;
`endif
    yCalc = bypassCap_q ? xCur : yNarrow;
  end

  // Controller next-state logic. INIT reuses wrPtr/chan as the sweep
  // address, which leaves both at zero when the sweep completes.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    wrPtr_d     = wrPtr_q;
    inCap_d     = inCap_q;
    delayCap_d  = delayCap_q;
    bypassCap_d = bypassCap_q;
    yBuf_d      = yBuf_q;
    outData_d   = outData_q;
    outValid_d  = 1'b0;
    overrun_d   = overrun_q;
    ramWe       = 1'b0;
    ramAddr     = {wrPtr_q, chan_q};
    ramWdata    = '0;

    if (frameEvent && (state_q != IDLE) && (state_q != INIT)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      INIT: begin
        ramWe    = 1'b1;
        ramWdata = '0;
        if (chan_q == LastChan) begin
          chan_d  = '0;
          wrPtr_d = wrPtr_q + ADDRBITS'(1);
          if (wrPtr_q == '1) begin
            state_d = IDLE;
          end
        end else begin
          chan_d = chan_q + CW'(1);
        end
      end
      IDLE: begin
        if (frameEvent) begin
          inCap_d     = in_data;
          delayCap_d  = delay;
          bypassCap_d = bypass;
          chan_d      = '0;
          state_d     = READ;
        end
      end
      READ: begin
        ramAddr = {wrPtr_q - delayCap_q, chan_q};
        state_d = CALC;
      end
      CALC: begin
        yBuf_d[chan_q*BITSIZE +: BITSIZE] = yCalc;
        state_d = WRITE;
      end
      WRITE: begin
        ramWe    = 1'b1;
        ramWdata = yBuf_q[chan_q*BITSIZE +: BITSIZE];
        if (chan_q == LastChan) begin
          state_d = DONE;
        end else begin
          chan_d  = chan_q + CW'(1);
          state_d = READ;
        end
      end
      DONE: begin
        outValid_d = 1'b1;
        outData_d  = yBuf_q;
        wrPtr_d    = wrPtr_q + ADDRBITS'(1);
        state_d    = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and restarts the
  // memory sweep.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      chan_q      <= '0;
      wrPtr_q     <= '0;
      inCap_q     <= '0;
      delayCap_q  <= '0;
      bypassCap_q <= 1'b0;
      yBuf_q      <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      wrPtr_q     <= wrPtr_d;
      inCap_q     <= inCap_d;
      delayCap_q  <= delayCap_d;
      bypassCap_q <= bypassCap_d;
      yBuf_q      <= yBuf_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule
